// File: rtl/blackparrot_fpga_host_bootrom_arbiter_if.sv
// Host-side NBF write / MMIO read ports plus the single-port bootrom bus.
// The arbiter takes the slave view; the host/memory environment the master.
interface blackparrot_fpga_host_bootrom_arbiter_if #(
  parameter int width_p = 64,
  parameter int addr_w  = 13
);
  localparam int mask_w = width_p / 8;

  logic              w_i;
  logic [addr_w-1:0] w_addr_i;
  logic [width_p-1:0] data_i;
  logic [mask_w-1:0] w_mask_i;
  logic              w_yumi_o;

  logic              v_i;
  logic [addr_w-1:0] r_addr_i;
  logic              r_yumi_o;
  logic              v_o;
  logic [width_p-1:0] data_o;
  logic              r_yumi_i;

  logic              mem_v_o;
  logic              mem_w_o;
  logic [addr_w-1:0] mem_addr_o;
  logic [width_p-1:0] mem_data_o;
  logic [mask_w-1:0] mem_mask_o;
  logic [width_p-1:0] mem_data_i;

  modport slave (
    input  w_i, w_addr_i, data_i, w_mask_i,
    input  v_i, r_addr_i, r_yumi_i, mem_data_i,
    output w_yumi_o, r_yumi_o, v_o, data_o,
    output mem_v_o, mem_w_o, mem_addr_o,
    output mem_data_o, mem_mask_o
  );

  modport master (
    output w_i, w_addr_i, data_i, w_mask_i,
    output v_i, r_addr_i, r_yumi_i, mem_data_i,
    input  w_yumi_o, r_yumi_o, v_o, data_o,
    input  mem_v_o, mem_w_o, mem_addr_o,
    input  mem_data_o, mem_mask_o
  );
endinterface

// File: rtl/blackparrot_fpga_host_bootrom_arbiter.sv
// Round-robin arbiter between host writes and MMIO reads onto one
// single-port bootrom; reads return through a one-entry output register.
module blackparrot_fpga_host_bootrom_arbiter #(
  parameter int bootrom_width_p = 64,
  parameter int bootrom_els_p   = 8192,
  localparam int addr_w =
    (bootrom_els_p <= 1) ? 1 : $clog2(bootrom_els_p),
  localparam int mask_w = bootrom_width_p / 8
) (
  input logic clk_i,
  input logic reset_i,
  blackparrot_fpga_host_bootrom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     last_w_q;
  logic                     v_q;
  logic [bootrom_width_p-1:0] data_q;

  logic rd_elig;
  logic wr_elig;
  logic grant_r;
  logic grant_w;

  // Grants are forced low while reset is held, even mid-cycle.
  always_comb begin
    rd_elig = !reset_i && bus.v_i &&
              ((state_q == IDLE) ||
               ((state_q == RESP) && bus.r_yumi_i));
    wr_elig = !reset_i && bus.w_i;
    grant_w = wr_elig && (!rd_elig || !last_w_q);
    grant_r = rd_elig && (!wr_elig || last_w_q);
  end

  always_comb begin
    bus.mem_v_o    = 1'b0;
    bus.mem_w_o    = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    bus.mem_mask_o = '0;
    unique case (1'b1)
      grant_w: begin
        bus.mem_v_o    = 1'b1;
        bus.mem_w_o    = 1'b1;
        bus.mem_addr_o = bus.w_addr_i;
        bus.mem_data_o = bus.data_i;
        bus.mem_mask_o = bus.w_mask_i;
      end
      grant_r: begin
        bus.mem_v_o    = 1'b1;
        bus.mem_addr_o = bus.r_addr_i;
      end
      default: ;
    endcase
  end

  assign bus.w_yumi_o = grant_w;
  assign bus.r_yumi_o = grant_r;
  assign bus.v_o      = v_q;
  assign bus.data_o   = data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_w_q <= 1'b0;
      v_q      <= 1'b0;
      data_q   <= '0;
    end else begin
      if (grant_w || grant_r) last_w_q <= grant_w;
      unique case (state_q)
        IDLE: if (grant_r) state_q <= WAIT;
        WAIT: begin
          data_q  <= bus.mem_data_i;
          v_q     <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (bus.r_yumi_i) begin
          v_q     <= 1'b0;
          state_q <= grant_r ? WAIT : IDLE;
        end
        default: begin
          v_q     <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blackparrot_fpga_host_bootrom_arbiter.sv
// Random host traffic against a word-array memory reference and a
// queue of expected read responses.
module tb_blackparrot_fpga_host_bootrom_arbiter;

  localparam int W  = 64;
  localparam int AW = 13;
  localparam int MW = W / 8;

  logic clk_i;
  logic reset_i;
  logic chk_en;

  blackparrot_fpga_host_bootrom_arbiter_if #(
    .width_p(W), .addr_w(AW)
  ) bus ();

  blackparrot_fpga_host_bootrom_arbiter #(
    .bootrom_width_p(W), .bootrom_els_p(8192)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int n_chk;
  int n_fail;

  logic [W-1:0] env_mem [16];
  logic [W-1:0] ref_mem [16];
  logic [W-1:0] sbq [$];

  int ph;
  bit last_w;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(string nm, logic [W-1:0] act,
                       logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(
    logic [W-1:0] old, logic [W-1:0] nw, logic [MW-1:0] m);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++)
      if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Memory device: read data valid only the cycle after a read.
  always @(posedge clk_i) begin
    if (bus.mem_v_o && bus.mem_w_o)
      env_mem[bus.mem_addr_o[3:0]] <=
        merge(env_mem[bus.mem_addr_o[3:0]],
              bus.mem_data_o, bus.mem_mask_o);
    if (bus.mem_v_o && !bus.mem_w_o)
      bus.mem_data_i <= env_mem[bus.mem_addr_o[3:0]];
    else
      bus.mem_data_i <= {$urandom, $urandom};
  end

  // ph: 0 no read outstanding, 1 data due next cycle, 2 data held.
  always @(negedge clk_i) begin
    bit rd_ok, ew, er;
    if (reset_i) begin
      ph = 0;
      last_w = 1'b0;
      sbq.delete();
    end else if (chk_en) begin
      rd_ok = bus.v_i &&
              (ph == 0 || (ph == 2 && bus.r_yumi_i));
      if (bus.w_i && rd_ok) begin
        ew = !last_w;
        er = last_w;
      end else begin
        ew = bus.w_i;
        er = rd_ok;
      end
      check("w_yumi", W'(bus.w_yumi_o), W'(ew));
      check("r_yumi", W'(bus.r_yumi_o), W'(er));
      check("one_yumi",
            W'(bus.w_yumi_o && bus.r_yumi_o), '0);
      check("mem_v", W'(bus.mem_v_o), W'(ew || er));
      check("v_o", W'(bus.v_o), W'(ph == 2));
      if (ew) begin
        check("wr_mem_w", W'(bus.mem_w_o), W'(1));
        check("wr_addr", W'(bus.mem_addr_o), W'(bus.w_addr_i));
        check("wr_data", bus.mem_data_o, bus.data_i);
        check("wr_mask", W'(bus.mem_mask_o), W'(bus.w_mask_i));
        ref_mem[bus.w_addr_i[3:0]] =
          merge(ref_mem[bus.w_addr_i[3:0]],
                bus.data_i, bus.w_mask_i);
        last_w = 1'b1;
      end
      if (er) begin
        check("rd_mem_w", W'(bus.mem_w_o), '0);
        check("rd_addr", W'(bus.mem_addr_o), W'(bus.r_addr_i));
        check("rd_mask", W'(bus.mem_mask_o), '0);
        sbq.push_back(ref_mem[bus.r_addr_i[3:0]]);
        last_w = 1'b0;
      end
      if (er) ph = 1;
      else if (ph == 1) ph = 2;
      else if (ph == 2 && bus.r_yumi_i) ph = 0;
    end
  end

  // Response monitor: every presented word must match the oldest read.
  always @(negedge clk_i) begin
    if (!reset_i && chk_en && bus.v_o) begin
      if (sbq.size() == 0) begin
        check("unexpected_v_o", W'(bus.v_o), '0);
      end else begin
        check("rd_data", bus.data_o, sbq[0]);
        if (bus.r_yumi_i) void'(sbq.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    bus.w_i      = 1'b0;
    bus.v_i      = 1'b0;
    bus.r_yumi_i = 1'b0;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.w_i      = 1'b0;
      bus.v_i      = 1'b0;
      bus.r_yumi_i = bus.v_o;
    end
    cyc();
    bus.r_yumi_i = 1'b0;
  endtask

  task automatic rand_wr();
    bus.w_addr_i = AW'($urandom_range(0, 15));
    bus.data_i   = {$urandom, $urandom};
    bus.w_mask_i = MW'($urandom);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    reset_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = {$urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    bus.w_i      = 1'b1;
    bus.v_i      = 1'b1;
    bus.r_yumi_i = 1'b0;
    bus.w_addr_i = '0;
    bus.r_addr_i = '0;
    bus.data_i   = '0;
    bus.w_mask_i = '0;
    repeat (3) cyc();
    check("rst_v_o", W'(bus.v_o), '0);
    check("rst_data_o", bus.data_o, '0);
    check("rst_w_yumi", W'(bus.w_yumi_o), '0);
    check("rst_r_yumi", W'(bus.r_yumi_o), '0);
    check("rst_mem_v", W'(bus.mem_v_o), '0);

    // Tie right after reset: write must win first.
    chk_en  = 1'b1;
    reset_i = 1'b0;
    rand_wr();
    bus.r_addr_i = AW'(2);
    #1;
    check("tie_first_w", W'(bus.w_yumi_o), W'(1));
    for (int i = 0; i < 16; i++) begin
      cyc();
      rand_wr();
      bus.r_addr_i = AW'($urandom_range(0, 15));
      bus.r_yumi_i = bus.v_o;
    end
    idle_in();
    drain(4);

    bus.w_i      = 1'b1;
    bus.w_addr_i = AW'(5);
    bus.data_i   = 64'hDEAD_BEEF_0123_4567;
    bus.w_mask_i = 8'hFF;
    #1;
    check("w5_yumi", W'(bus.w_yumi_o), W'(1));
    check("w5_addr", W'(bus.mem_addr_o), W'(5));
    cyc();
    bus.w_i      = 1'b0;
    bus.v_i      = 1'b1;
    bus.r_addr_i = AW'(5);
    cyc();
    bus.v_i = 1'b1;
    cyc();
    check("r5_latency", W'(bus.v_o), W'(1));
    for (int i = 0; i < 10; i++) begin
      bus.w_i = 1'b1;
      rand_wr();
      #1;
      check("bp_r_yumi", W'(bus.r_yumi_o), '0);
      check("bp_w_yumi", W'(bus.w_yumi_o), W'(1));
      check("bp_data", bus.data_o, 64'hDEAD_BEEF_0123_4567);
      cyc();
    end
    bus.w_i      = 1'b0;
    bus.r_yumi_i = 1'b1;
    #1;
    check("b2b_r_yumi", W'(bus.r_yumi_o), W'(1));
    cyc();
    bus.v_i      = 1'b0;
    bus.r_yumi_i = 1'b0;
    check("b2b_wait_v", W'(bus.v_o), '0);
    cyc();
    check("b2b_resp_v", W'(bus.v_o), W'(1));
    drain(4);

    for (int i = 0; i < 1500; i++) begin
      bus.w_i      = ($urandom_range(0, 2) != 0);
      bus.v_i      = ($urandom_range(0, 2) != 0);
      bus.r_addr_i = AW'($urandom_range(0, 15));
      rand_wr();
      bus.r_yumi_i = bus.v_o && ($urandom_range(0, 2) != 0);
      cyc();
    end
    idle_in();
    drain(6);

    // Reset while the read is waiting on memory data.
    bus.v_i      = 1'b1;
    bus.r_addr_i = AW'(3);
    cyc();
    bus.w_i = 1'b1;
    #2;
    reset_i = 1'b1;
    #1;
    check("rw_v_o", W'(bus.v_o), '0);
    check("rw_mem_v", W'(bus.mem_v_o), '0);
    check("rw_w_yumi", W'(bus.w_yumi_o), '0);
    check("rw_r_yumi", W'(bus.r_yumi_o), '0);
    cyc();
    cyc();
    reset_i = 1'b0;
    idle_in();
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("post_rst_v_o", W'(bus.v_o), '0);
    end
    drain(4);
    check("sb_empty", W'(sbq.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blackparrot_fpga_host_bootrom_arbiter.md
BLACKPARROT_FPGA_HOST_BOOTROM_ARBITER -- requirements
Module: blackparrot_fpga_host_bootrom_arbiter

Interface
REQ-001 Parameter: bootrom_width_p, default 64, data width in bits; must be a multiple of 8.
REQ-002 Parameter: bootrom_els_p, default 8192, memory depth in words; addr_w = BSG_SAFE_CLOG2(bootrom_els_p).
REQ-003 Clocking: one clock; reset is asynchronous and active-high (clk_i, reset_i).
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  in  1  asynchronous active-high reset.
REQ-006 w_i  in  1  NBF write request valid.
REQ-007 w_addr_i  in  addr_w  write word address.
REQ-008 data_i  in  bootrom_width_p  write data.
REQ-009 w_mask_i  in  bootrom_width_p/8  write byte enables.
REQ-010 w_yumi_o  out  1  write accepted this cycle.
REQ-011 v_i  in  1  MMIO read request valid.
REQ-012 r_addr_i  in  addr_w  read word address.
REQ-013 r_yumi_o  out  1  read request accepted this cycle.
REQ-014 v_o  out  1  read data valid.
REQ-015 data_o  out  bootrom_width_p  read data.
REQ-016 r_yumi_i  in  1  consumer takes data_o this cycle; legal only while v_o=1.
REQ-017 mem_v_o  out  1  single-port memory access enable.
REQ-018 mem_w_o  out  1  1=write, 0=read; meaningful only when mem_v_o=1.
REQ-019 mem_addr_o  out  addr_w  memory word address.
REQ-020 mem_data_o  out  bootrom_width_p  memory write data.
REQ-021 mem_mask_o  out  bootrom_width_p/8  memory byte enables.
REQ-022 mem_data_i  in  bootrom_width_p  memory read data, valid exactly one cycle after a read access.

Function
REQ-023 At most one memory access per cycle; w_yumi_o and r_yumi_o are never both 1.
REQ-024 Read FSM states: IDLE, WAIT (read issued, data due next cycle), RESP (data held in output register).
REQ-025 Read eligible = v_i AND (state==IDLE OR (state==RESP AND r_yumi_i)); reads never issue in WAIT.
REQ-026 Write eligible = w_i, in any state; a write never disturbs held read data.
REQ-027 Only one eligible: that requester is granted in the same cycle (yumi combinational from inputs and state).
REQ-028 Both eligible: grant the requester not granted most recently (1-bit last_grant register, updated on every grant).
REQ-029 Write grant: mem_v_o=1, mem_w_o=1, mem_addr_o=w_addr_i, mem_data_o=data_i, mem_mask_o=w_mask_i, w_yumi_o=1.
REQ-030 Read grant: mem_v_o=1, mem_w_o=0, mem_addr_o=r_addr_i, mem_mask_o=0, r_yumi_o=1; next state WAIT.
REQ-031 No grant: mem_v_o=0; other mem outputs don't-care but driven to 0.
REQ-032 WAIT: capture mem_data_i into data_o register; next state RESP unconditionally.
REQ-033 RESP: v_o=1, data_o stable; r_yumi_i without new read grant -> IDLE; r_yumi_i with read grant -> WAIT; else stay.
REQ-034 v_o=0 in IDLE and WAIT; data_o retains last captured value outside RESP.
REQ-035 Read latency: grant cycle N -> v_o=1 in cycle N+2; sustained read throughput one per 2 cycles.
REQ-036 Write then read to same address in consecutive grants returns written data (memory ordering preserved; no bypass).
REQ-037 No request is dropped: a requester with valid held high is granted within 2 eligible arbitration cycles.

Reset
REQ-038 While reset_i=1: state=IDLE, last_grant=read (write wins first tie), data_o=0, v_o=0, w_yumi_o=0, r_yumi_o=0, mem_v_o=0.
REQ-039 Reset asserted mid-read (WAIT or RESP): pending read discarded; after deassert no v_o until a new read is granted.
REQ-040 First grant possible in first cycle after reset_i deasserts.

Verification
REQ-041 Write-only: w_i=1, w_addr_i=5, data_i=64'hDEAD_BEEF_0123_4567, mask=8'hFF -> w_yumi_o=1, mem_v_o=1, mem_w_o=1, mem_addr_o=5 same cycle.
REQ-042 Read: v_i=1, r_addr_i=5 in IDLE at cycle N; memory returns 64'hDEAD_BEEF_0123_4567 at N+1 -> v_o=1, data_o equal at N+2, held until r_yumi_i.
REQ-043 Tie after reset: w_i=v_i=1 held -> grants W,R (R blocked until RESP+r_yumi_i), then alternation W,R when both eligible; never both yumis.
REQ-044 Backpressure: v_o=1, r_yumi_i=0 for 10 cycles with v_i=1 -> r_yumi_o=0 throughout, writes still granted, data_o unchanged.
REQ-045 Back-to-back: RESP with r_yumi_i=1 and v_i=1, w_i=0 -> r_yumi_o=1 same cycle, state WAIT, v_o=0 next cycle, v_o=1 cycle after.
REQ-046 Reset in WAIT: assert reset_i asynchronously -> v_o, mem_v_o, yumis 0 immediately; after deassert v_o stays 0 with v_i=0.
